// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU and its accumulator sequencer.
// Holds the ALU opcodes, the command encoding and the sequencer state type.
package alu4_pkg;

  localparam logic [2:0] OP_NOTA = 3'b000;
  localparam logic [2:0] OP_NOTB = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  localparam logic CMD_LOAD = 1'b0;
  localparam logic CMD_EXEC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

endpackage

// File: rtl/alu4.sv
// Purely combinational 4-bit ALU with carry, negative, zero and overflow flags.
// SUB computes a + ~b + 1, so c=1 means no borrow.
module alu4
  import alu4_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       c,
  output logic       n,
  output logic       z,
  output logic       v
);

  logic [4:0] sum;

  always_comb begin
    sum    = 5'd0;
    result = 4'd0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[3:0];
        c      = sum[4];
        v      = (a[3] == b[3]) && (result[3] != a[3]);
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + 5'd1;
        result = sum[3:0];
        c      = sum[4];
        v      = (a[3] != b[3]) && (result[3] != a[3]);
      end
      default: result = 4'd0;
    endcase
    n = result[3];
    z = (result == 4'd0);
  end

endmodule

// File: rtl/alu4_acc_fsm.sv
// Sequencer control for alu4_acc_ctrl: IDLE accepts, EXEC waits one ALU cycle,
// HOLD presents the result until the consumer takes it.
module alu4_acc_fsm
  import alu4_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_valid,
  input  logic i_cmd,
  input  logic o_ready,
  output logic i_ready,
  output logic o_valid,
  output logic accept,
  output logic load_fire,
  output logic exec_capture
);

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    i_ready      = 1'b0;
    o_valid      = 1'b0;
    accept       = 1'b0;
    load_fire    = 1'b0;
    exec_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) begin
          accept = 1'b1;
          if (i_cmd == CMD_EXEC) begin
            state_d = ST_EXEC;
          end else begin
            load_fire = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_EXEC: begin
        exec_capture = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        o_valid = 1'b1;
        if (o_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/alu4_acc_ctrl.sv
// Accumulator sequencer around alu4: latches commands, drives the ALU from registers,
// captures result/flags. Define ALU4_ACC_STICKY_V_EN to make o_v sticky across EXECs.
module alu4_acc_ctrl
  import alu4_pkg::*;
#(
  parameter logic [3:0] ACC_INIT = 4'h0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic       i_cmd,
  input  logic [2:0] i_op,
  input  logic [3:0] i_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_c,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_v,
  output logic       o_valid,
  input  logic       o_ready,
  output logic [3:0] o_acc,
  output logic       o_c,
  output logic       o_n,
  output logic       o_z,
  output logic       o_v
);

  logic       accept, load_fire, exec_capture;
  logic [3:0] acc_q, acc_d, b_q, b_d;
  logic [2:0] op_q, op_d;
  logic       c_q, c_d, n_q, n_d, z_q, z_d, v_q, v_d;

  alu4_acc_fsm u_fsm (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_valid      (i_valid),
    .i_cmd        (i_cmd),
    .o_ready      (o_ready),
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .accept       (accept),
    .load_fire    (load_fire),
    .exec_capture (exec_capture)
  );

  always_comb begin
    acc_d = acc_q;
    b_d   = b_q;
    op_d  = op_q;
    c_d   = c_q;
    n_d   = n_q;
    z_d   = z_q;
    v_d   = v_q;
    if (accept) begin
      b_d  = i_data;
      op_d = i_op;
    end
    if (load_fire) begin
      acc_d = i_data;
      c_d   = 1'b0;
      n_d   = i_data[3];
      z_d   = (i_data == 4'h0);
      v_d   = 1'b0;
    end else if (exec_capture) begin
      acc_d = alu_result;
      c_d   = alu_c;
      n_d   = alu_n;
      z_d   = alu_z;
`ifdef ALU4_ACC_STICKY_V_EN
      v_d   = alu_v | v_q;
`else
      v_d   = alu_v;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q <= ACC_INIT;
      b_q   <= 4'h0;
      op_q  <= 3'b000;
      c_q   <= 1'b0;
      n_q   <= 1'b0;
      z_q   <= 1'b0;
      v_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      op_q  <= op_d;
      c_q   <= c_d;
      n_q   <= n_d;
      z_q   <= z_d;
      v_q   <= v_d;
    end
  end

  assign alu_a  = acc_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign o_acc  = acc_q;
  assign o_c    = c_q;
  assign o_n    = n_q;
  assign o_z    = z_q;
  assign o_v    = v_q;

endmodule

// File: tb/tb_alu4_acc_ctrl.sv
// Self-checking bench for alu4_acc_ctrl wired to alu4: table vectors, corner sequences
// and random commands against an arithmetic reference model.
module tb_alu4_acc_ctrl;
  import alu4_pkg::*;

`ifdef ALU4_ACC_STICKY_V_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_valid, i_ready, i_cmd;
  logic [2:0] i_op;
  logic [3:0] i_data;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_c, alu_n, alu_z, alu_v;
  logic       o_valid, o_ready;
  logic [3:0] o_acc;
  logic       o_c, o_n, o_z, o_v;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] acc;
    logic       c, n, z, v;
  } res_t;

  typedef struct packed {
    logic       cmd;
    logic [2:0] op;
    logic [3:0] data;
    res_t       exp;
  } vec_t;

  always #5 clk = ~clk;

  alu4_acc_ctrl #(.ACC_INIT(4'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_valid(i_valid), .i_ready(i_ready), .i_cmd(i_cmd), .i_op(i_op), .i_data(i_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_acc(o_acc), .o_c(o_c), .o_n(o_n), .o_z(o_z), .o_v(o_v)
  );

  alu4 u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op),
    .result(alu_result), .c(alu_c), .n(alu_n), .z(alu_z), .v(alu_v)
  );

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic res_t model(input res_t cur, input logic cmd,
                                 input logic [2:0] op, input logic [3:0] data);
    res_t r;
    int a, b, sa, sb, s;
    logic [3:0] la, lb;
    a  = int'(cur.acc);
    b  = int'(data);
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    la = cur.acc;
    lb = data;
    r  = '0;
    if (cmd == CMD_LOAD) begin
      r.acc = data;
    end else begin
      case (op)
        OP_NOTA: r.acc = ~la;
        OP_NOTB: r.acc = ~lb;
        OP_AND:  r.acc = la & lb;
        OP_OR:   r.acc = la | lb;
        OP_XOR:  r.acc = la ^ lb;
        OP_XNOR: r.acc = ~(la ^ lb);
        OP_ADD: begin
          s     = a + b;
          r.acc = 4'(s % 16);
          r.c   = (s > 15);
          s     = sa + sb;
          r.v   = (s > 7) || (s < -8);
        end
        default: begin
          s     = a - b;
          r.acc = 4'((s + 16) % 16);
          r.c   = (a >= b);
          s     = sa - sb;
          r.v   = (s > 7) || (s < -8);
        end
      endcase
      if (STICKY) r.v = r.v | cur.v;
    end
    r.n = (r.acc >= 4'd8);
    r.z = (r.acc == 4'd0);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkRes(input string name, input res_t exp);
    checkOutput({name, "_acc"}, {4'h0, o_acc}, {4'h0, exp.acc});
    checkOutput({name, "_flags"}, {4'h0, o_c, o_n, o_z, o_v},
                {4'h0, exp.c, exp.n, exp.z, exp.v});
  endtask

  // Offers a command and returns once the accepting edge has passed.
  task automatic applyStimulus(input logic cmd, input logic [2:0] op, input logic [3:0] data);
    bit ok;
    ok      = 1'b0;
    i_valid = 1'b1;
    i_cmd   = cmd;
    i_op    = op;
    i_data  = data;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (i_ready) ok = 1'b1;
      step();
    end
    i_valid = 1'b0;
    if (!ok) checkOutput("accept_timeout", 8'h0, 8'h1);
  endtask

  // Full command: accept, latency, result, handshake, o_valid drop.
  task automatic runCmd(input string name, input logic cmd, input logic [2:0] op,
                        input logic [3:0] data, input res_t exp);
    applyStimulus(cmd, op, data);
    if (cmd == CMD_EXEC) begin
      checkOutput({name, "_lat_t1"}, {7'h0, o_valid}, 8'h0);
      step();
    end
    checkOutput({name, "_valid"}, {7'h0, o_valid}, 8'h1);
    checkOutput({name, "_iready_busy"}, {7'h0, i_ready}, 8'h0);
    checkRes(name, exp);
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    checkOutput({name, "_drop"}, {7'h0, o_valid}, 8'h0);
    checkOutput({name, "_idle_ready"}, {7'h0, i_ready}, 8'h1);
    checkRes({name, "_hold_idle"}, exp);
  endtask

  vec_t vecs[18];
  res_t cur;

  initial begin
    reset_n = 1'b0;
    i_valid = 1'b1;
    i_cmd   = CMD_LOAD;
    i_op    = 3'b000;
    i_data  = 4'hF;
    o_ready = 1'b0;

    vecs[0]  = '{CMD_LOAD, OP_NOTA, 4'h5, '{4'h5, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{CMD_EXEC, OP_ADD,  4'h3, '{4'h8, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[2]  = '{CMD_LOAD, OP_SUB,  4'h8, '{4'h8, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{CMD_EXEC, OP_SUB,  4'h8, '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{CMD_LOAD, OP_ADD,  4'h0, '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[5]  = '{CMD_LOAD, OP_NOTA, 4'hA, '{4'hA, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[6]  = '{CMD_EXEC, OP_AND,  4'hC, '{4'h8, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = '{CMD_EXEC, OP_XOR,  4'hF, '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{CMD_EXEC, OP_NOTA, 4'h0, '{4'h8, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[9]  = '{CMD_EXEC, OP_OR,   4'h3, '{4'hB, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[10] = '{CMD_EXEC, OP_XNOR, 4'hB, '{4'hF, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[11] = '{CMD_EXEC, OP_NOTB, 4'h5, '{4'hA, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[12] = '{CMD_EXEC, OP_ADD,  4'h9, '{4'h3, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[13] = '{CMD_EXEC, OP_ADD,  4'h0, '{4'h3, 1'b0, 1'b0, 1'b0, STICKY}};
    vecs[14] = '{CMD_LOAD, OP_ADD,  4'h7, '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[15] = '{CMD_EXEC, OP_ADD,  4'h1, '{4'h8, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[16] = '{CMD_EXEC, OP_ADD,  4'h0, '{4'h8, 1'b0, 1'b1, 1'b0, STICKY}};
    vecs[17] = '{CMD_LOAD, OP_ADD,  4'h0, '{4'h0, 1'b0, 1'b0, 1'b1, 1'b0}};

    // Reset held two cycles with a command offered.
    step();
    step();
    reset_n = 1'b1;
    i_valid = 1'b0;
    checkOutput("rst_iready", {7'h0, i_ready}, 8'h1);
    checkOutput("rst_ovalid", {7'h0, o_valid}, 8'h0);
    checkRes("rst", '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    checkOutput("rst_nothing_taken", {7'h0, o_valid}, 8'h0);

    for (int i = 0; i < 18; i++)
      runCmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].op, vecs[i].data, vecs[i].exp);

    // Backpressure: result held while a second command waits.
    runCmd("bp_load", CMD_LOAD, OP_NOTA, 4'hA, '{4'hA, 1'b0, 1'b1, 1'b0, 1'b0});
    applyStimulus(CMD_EXEC, OP_AND, 4'hC);
    step();
    i_valid = 1'b1;
    i_cmd   = CMD_LOAD;
    i_data  = 4'h1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_valid", {7'h0, o_valid}, 8'h1);
      checkOutput("bp_acc", {4'h0, o_acc}, 8'h08);
      checkOutput("bp_iready", {7'h0, i_ready}, 8'h0);
      step();
    end
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;
    checkOutput("bp_no_bypass", {4'h0, o_acc}, 8'h08);
    checkOutput("bp_idle_ready", {7'h0, i_ready}, 8'h1);
    step();
    i_valid = 1'b0;
    checkOutput("bp_second_valid", {7'h0, o_valid}, 8'h1);
    checkOutput("bp_second_acc", {4'h0, o_acc}, 8'h01);
    o_ready = 1'b1;
    step();
    o_ready = 1'b0;

    // Reset during EXEC: command lost.
    runCmd("rx_load", CMD_LOAD, OP_NOTA, 4'h3, '{4'h3, 1'b0, 1'b0, 1'b0, 1'b0});
    applyStimulus(CMD_EXEC, OP_ADD, 4'h1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checkOutput("rx_ovalid", {7'h0, o_valid}, 8'h0);
    checkOutput("rx_iready", {7'h0, i_ready}, 8'h1);
    checkRes("rx", '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    step();
    checkOutput("rx_never_reported", {7'h0, o_valid}, 8'h0);

    // Random commands against the reference model.
    cur = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 60; i++) begin
      logic       rc;
      logic [2:0] rop;
      logic [3:0] rd;
      rc   = 1'($urandom_range(0, 3) != 0);
      rop  = 3'($urandom_range(0, 7));
      rd   = 4'($urandom_range(0, 15));
      cur  = model(cur, rc, rop, rd);
      runCmd($sformatf("rnd%0d", i), rc, rop, rd, cur);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu4_acc_ctrl.md
Name: alu4_acc_ctrl

Overview:
- Accumulator sequencer wrapped around the 4-bit ALU (alu4).
- Upstream, it accepts commands over a valid/ready handshake and drives the ALU's a/b/op inputs (a = accumulator, b = command operand).
- Downstream, it registers the ALU's result and c/n/z/v flags into the accumulator and flag register, then presents them over a second valid/ready handshake.

Parameters:
- ACC_INIT, 4'h0, accumulator value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- i_valid  input  1  command valid.
- i_ready  output  1  block can accept a command.
- i_cmd  input  1  0 = LOAD, 1 = EXEC.
- i_op  input  3  ALU opcode for EXEC; ignored for LOAD.
- i_data  input  4  LOAD value, or b operand for EXEC.
- alu_a  output  4  to ALU a (equals the accumulator).
- alu_b  output  4  to ALU b (latched operand).
- alu_op  output  3  to ALU op (latched opcode).
- alu_result  input  4  from ALU result.
- alu_c, alu_n, alu_z, alu_v  input  1 each  from ALU flags.
- o_valid  output  1  result/flags valid.
- o_ready  input  1  consumer accepts.
- o_acc  output  4  accumulator.
- o_c, o_n, o_z, o_v  output  1 each  registered flags.

Behaviour:
- Reset (reset_n low at a clk edge):
  - state=IDLE, acc=ACC_INIT, flags=0, o_valid=0.
  - Latched operand and opcode = 0.
  - i_ready=1 from the first cycle after reset release.
  - Reset overrides everything, including a command in flight or a pending output; that command is lost.
- FSM states IDLE, EXEC, HOLD:
  - IDLE: i_ready=1. On i_valid, latch cmd/op/data.
    - EXEC command -> EXEC state.
    - LOAD command -> writes acc=i_data, c=0, v=0, n=i_data[3], z=(i_data==0) at the same edge, then -> HOLD.
  - EXEC: ALU inputs stable for one full cycle (ALU is purely combinational). At end of cycle, capture acc=alu_result and c/n/z/v=alu flags -> HOLD.
  - HOLD: o_valid=1, with o_acc and flags stable. On o_ready -> IDLE, o_valid drops the next cycle.
- i_ready is 0 in EXEC and HOLD; commands presented there are not consumed (source must hold them).
- Latency:
  - EXEC: accept edge T, o_valid at T+2.
  - LOAD: o_valid at T+1.
  - Max throughput: EXEC one per 3 cycles, LOAD one per 2, with o_ready held high.
- No bypass: a command offered in the same cycle HOLD completes is not accepted until the following IDLE cycle.
- alu_a/alu_b/alu_op are always driven from registers (no combinational path from i_* to the ALU).
- Flags are passed through unmodified from the ALU, so c/v semantics are the ALU's (meaningful for op 110 ADD and 111 SUB). acc wraps mod 16.
- o_acc and flags hold their values in IDLE; they only update on LOAD or EXEC capture.

Optional Feature:
- ALU4_ACC_STICKY_V_EN:
  - Defined: o_v is sticky. It is OR-accumulated across consecutive EXEC captures and cleared only by LOAD or reset.
  - Undefined: o_v reflects only the most recent operation.
- All other flags are unaffected either way.

Decomposition:
- Package alu4_pkg holds:
  - Opcode constants: OP_NOTA=3'b000, OP_NOTB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_XNOR=3'b101, OP_ADD=3'b110, OP_SUB=3'b111.
  - CMD_LOAD/CMD_EXEC.
  - FSM state encoding.
- One natural sub-module, alu4_acc_fsm (state register plus next-state/handshake logic). The datapath registers stay in alu4_acc_ctrl.
- The testbench instantiates alu4 alongside the block.

Test Plan:
- Reset held 2 cycles with i_valid=1 -> i_ready=1 after release, o_valid=0, o_acc=0, flags 0000; nothing accepted during reset.
- LOAD 4'h5, then EXEC ADD 4'h3, o_ready=1 -> o_acc=4'h8, c=0, n=1, z=0, v=1; o_valid exactly 2 cycles after the EXEC accept edge.
- LOAD 4'h8, then EXEC SUB 4'h8 -> o_acc=4'h0, z=1, c=1, n=0, v=0; LOAD 4'h0 alone gives z=1, c=0, v=0.
- Backpressure: after EXEC AND 4'hC on acc=4'hA, hold o_ready=0 for 3 cycles -> o_valid=1 and o_acc=4'h8 stable, i_ready=0, and a second command offered meanwhile is not consumed.
- Reset asserted in the EXEC cycle -> next cycle acc=ACC_INIT, o_valid=0, state IDLE; the command is never reported.
- Sticky V with ALU4_ACC_STICKY_V_EN: LOAD 7, ADD 1 (v=1), then LOAD-free ADD 0 -> o_v stays 1; then LOAD 0 -> o_v=0. Without the macro, ADD 0 gives o_v=0.
